// File: rtl/subtract_pkg.sv
// Shared types and constants for the background-subtract datapath.
package subtract_pkg;

    localparam int unsigned PIXEL_W = 24;
    localparam int unsigned GRAY_W  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } sched_state_t;

    function automatic int unsigned pix_cnt_w(input int unsigned w, input int unsigned h);
        return $clog2(w * h + 1);
    endfunction

endpackage

// File: rtl/frame_pixel_counter.sv
// Per-frame pixel counter with synchronous clear and a flag marking the
// increment that reaches the terminal count.
module frame_pixel_counter #(
    parameter int unsigned Width    = 19,
    parameter int unsigned Terminal = 388800
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o,
    output logic             last_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    // High on the increment that takes the count to Terminal.
    assign last_o  = inc_i & (count_q == Width'(Terminal - 1));

endmodule

// File: rtl/subtract_frame_sched.sv
// Frame sequencer feeding the subtract input FIFOs in lockstep and tracking results.
// Define SUBTRACT_SCHED_STATS_EN to add the stall_cycles backpressure counter.
module subtract_frame_sched
    import subtract_pkg::*;
#(
    parameter int unsigned  WIDTH        = 720,
    parameter int unsigned  HEIGHT       = 540,
    localparam int unsigned FRAME_PIXELS = WIDTH * HEIGHT,
    localparam int unsigned PIX_W        = pix_cnt_w(WIDTH, HEIGHT)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               frame_done,
    input  logic [PIXEL_W-1:0] src_base_dout,
    input  logic               src_base_empty,
    output logic               src_base_rd_en,
    input  logic [PIXEL_W-1:0] src_img_dout,
    input  logic               src_img_empty,
    output logic               src_img_rd_en,
    output logic [PIXEL_W-1:0] sub_din_base,
    output logic               sub_wr_en_base,
    input  logic               sub_full_base,
    output logic [PIXEL_W-1:0] sub_din_img,
    output logic               sub_wr_en_img,
    input  logic               sub_full_img,
    input  logic               sub_out_empty,
    input  logic               sub_out_rd_en,
    output logic [PIX_W-1:0]   in_count,
    output logic [PIX_W-1:0]   out_count
`ifdef SUBTRACT_SCHED_STATS_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);

    sched_state_t state_q, state_d;
    logic         xfer;
    logic         pop;
    logic         frame_start;
    logic         in_last;
    logic         out_last;

    assign frame_start = (state_q == StIdle) & start;
    // A pair moves only when both sources have data and both destinations have room.
    assign xfer = (state_q == StRun) & ~src_base_empty & ~src_img_empty &
                  ~sub_full_base & ~sub_full_img;
    assign pop  = sub_out_rd_en & ~sub_out_empty &
                  ((state_q == StRun) | (state_q == StDrain));

    assign src_base_rd_en = xfer;
    assign src_img_rd_en  = xfer;
    assign sub_wr_en_base = xfer;
    assign sub_wr_en_img  = xfer;
    assign sub_din_base   = src_base_dout;
    assign sub_din_img    = src_img_dout;

    frame_pixel_counter #(
        .Width    (PIX_W),
        .Terminal (FRAME_PIXELS)
    ) u_in_cnt (
        .clk_i   (clock),
        .rst_ni  (reset),
        .clear_i (frame_start),
        .inc_i   (xfer),
        .count_o (in_count),
        .last_o  (in_last)
    );

    frame_pixel_counter #(
        .Width    (PIX_W),
        .Terminal (FRAME_PIXELS)
    ) u_out_cnt (
        .clk_i   (clock),
        .rst_ni  (reset),
        .clear_i (frame_start),
        .inc_i   (pop),
        .count_o (out_count),
        .last_o  (out_last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            // The final result can be popped alongside the final transfer.
            StRun: begin
                if (out_last) begin
                    state_d = StDone;
                end else if (in_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: if (out_last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign frame_done = (state_q == StDone);

`ifdef SUBTRACT_SCHED_STATS_EN
    logic        stall;
    logic [31:0] stall_q, stall_d;

    assign stall = (state_q == StRun) & ~src_base_empty & ~src_img_empty &
                   (sub_full_base | sub_full_img);

    always_comb begin
        stall_d = stall_q;
        if (frame_start) begin
            stall_d = '0;
        end else if (stall && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_subtract_frame_sched.sv
// Directed bench for subtract_frame_sched on a 4x2 frame with modelled sources,
// input FIFOs and a consumer on the subtract output.
module tb_subtract_frame_sched;

    localparam int unsigned W    = 4;
    localparam int unsigned H    = 2;
    localparam int          NPIX = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        frame_done;
    logic [23:0] src_base_dout;
    logic        src_base_empty;
    logic        src_base_rd_en;
    logic [23:0] src_img_dout;
    logic        src_img_empty;
    logic        src_img_rd_en;
    logic [23:0] sub_din_base;
    logic        sub_wr_en_base;
    logic        sub_full_base;
    logic [23:0] sub_din_img;
    logic        sub_wr_en_img;
    logic        sub_full_img;
    logic        sub_out_empty;
    logic        sub_out_rd_en;
    logic [3:0]  in_count;
    logic [3:0]  out_count;
`ifdef SUBTRACT_SCHED_STATS_EN
    logic [31:0] stall_cycles;
`endif

    logic        base_block;
    logic        out_free;
    logic        pop_en;
    logic        tb_clr;
    int          base_rp;
    int          img_rp;
    int          wr_b;
    int          wr_i;
    int          pops;
    logic [23:0] got_b [NPIX];
    logic [23:0] got_i [NPIX];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    subtract_frame_sched #(
        .WIDTH  (W),
        .HEIGHT (H)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .busy           (busy),
        .frame_done     (frame_done),
        .src_base_dout  (src_base_dout),
        .src_base_empty (src_base_empty),
        .src_base_rd_en (src_base_rd_en),
        .src_img_dout   (src_img_dout),
        .src_img_empty  (src_img_empty),
        .src_img_rd_en  (src_img_rd_en),
        .sub_din_base   (sub_din_base),
        .sub_wr_en_base (sub_wr_en_base),
        .sub_full_base  (sub_full_base),
        .sub_din_img    (sub_din_img),
        .sub_wr_en_img  (sub_wr_en_img),
        .sub_full_img   (sub_full_img),
        .sub_out_empty  (sub_out_empty),
        .sub_out_rd_en  (sub_out_rd_en),
        .in_count       (in_count),
        .out_count      (out_count)
`ifdef SUBTRACT_SCHED_STATS_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    // Sources preloaded with NPIX pairs; the output FIFO holds whatever was pushed but not popped.
    assign src_base_empty = base_block || (base_rp >= NPIX);
    assign src_img_empty  = (img_rp >= NPIX);
    assign src_base_dout  = 24'h10_0000 + 24'(base_rp);
    assign src_img_dout   = 24'h20_0000 + 24'(img_rp);
    assign sub_out_empty  = !out_free && (pops >= wr_b);
    assign sub_out_rd_en  = pop_en;

    always @(posedge clock) begin
        if (tb_clr) begin
            base_rp <= 0;
            img_rp  <= 0;
            wr_b    <= 0;
            wr_i    <= 0;
            pops    <= 0;
        end else begin
            if (src_base_rd_en) base_rp <= base_rp + 1;
            if (src_img_rd_en)  img_rp  <= img_rp + 1;
            if (sub_wr_en_base) begin
                if (wr_b < NPIX) got_b[wr_b[2:0]] <= sub_din_base;
                wr_b <= wr_b + 1;
            end
            if (sub_wr_en_img) begin
                if (wr_i < NPIX) got_i[wr_i[2:0]] <= sub_din_img;
                wr_i <= wr_i + 1;
            end
            if (sub_out_rd_en && !sub_out_empty) pops <= pops + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One frame; ranges are inclusive loop cycles counted from the first RUN cycle (-1 disables).
    task automatic run_frame(input string tag, input int exp_done, input int blk_lo,
                             input int blk_hi, input int full_lo, input int full_hi,
                             input int start_at, input int rst_at, input logic free,
                             input int exp_stall);
        int   n;
        int   done_n;
        logic aborted;
        tb_clr = 1'b1;
        step();
        tb_clr   = 1'b0;
        out_free = free;
        start    = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_clr_in"}, 32'(in_count), 32'd0);
        check({tag, "_clr_out"}, 32'(out_count), 32'd0);
        n       = 0;
        done_n  = -1;
        aborted = 1'b0;
        while (n < 40 && done_n < 0) begin
            base_block   = (n >= blk_lo) && (n <= blk_hi);
            sub_full_img = (n >= full_lo) && (n <= full_hi);
            start        = (n == start_at);
            if (n == rst_at) begin
                reset = 1'b0;
                #1;
                check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                check({tag, "_rst_in"}, 32'(in_count), 32'd0);
                check({tag, "_rst_out"}, 32'(out_count), 32'd0);
                check({tag, "_rst_rd"}, 32'(src_base_rd_en), 32'd0);
                @(negedge clock);
                reset   = 1'b1;
                aborted = 1'b1;
                break;
            end
            #1;
            check({tag, "_lockstep"}, 32'({src_base_rd_en, sub_wr_en_base, sub_wr_en_img}),
                  32'({3{src_img_rd_en}}));
            check({tag, "_wr_cnt_eq"}, 32'(wr_b), 32'(wr_i));
            if (base_block || sub_full_img) begin
                check({tag, "_blocked_rd"}, 32'(src_base_rd_en | src_img_rd_en), 32'd0);
            end
            if (start_at >= 0 && n == start_at + 1) begin
                check({tag, "_no_restart"}, 32'(in_count), 32'(n));
            end
            if (frame_done) begin
                done_n = n;
`ifdef SUBTRACT_SCHED_STATS_EN
                check({tag, "_stall"}, stall_cycles, 32'(exp_stall));
`endif
            end else begin
                step();
                n++;
            end
        end
        start        = 1'b0;
        base_block   = 1'b0;
        sub_full_img = 1'b0;
        if (!aborted) begin
            check({tag, "_done_cycle"}, 32'(done_n), 32'(exp_done));
            check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
            step();
            check({tag, "_done_pulse"}, 32'(frame_done), 32'd0);
            check({tag, "_busy_drop"}, 32'(busy), 32'd0);
            check({tag, "_in_count"}, 32'(in_count), 32'd8);
            check({tag, "_out_count"}, 32'(out_count), 32'd8);
            check({tag, "_wr_total"}, 32'(wr_b), 32'd8);
            for (int i = 0; i < NPIX; i++) begin
                check({tag, "_data_b"}, 32'(got_b[i]), 32'h10_0000 + 32'(i));
                check({tag, "_data_i"}, 32'(got_i[i]), 32'h20_0000 + 32'(i));
            end
        end
        out_free = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        start         = 1'b0;
        base_block    = 1'b0;
        sub_full_base = 1'b0;
        sub_full_img  = 1'b0;
        out_free      = 1'b0;
        pop_en        = 1'b0;
        tb_clr        = 1'b1;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(frame_done), 32'd0);
        check("reset_in", 32'(in_count), 32'd0);
        check("reset_out", 32'(out_count), 32'd0);
        check("reset_rd", 32'(src_base_rd_en | src_img_rd_en), 32'd0);
        step();
        @(negedge clock);
        reset  = 1'b1;
        pop_en = 1'b1;
        step();

        run_frame("basic", 9, -1, -1, -1, -1, -1, -1, 1'b0, 0);

        // Pops while idle must not move the held counts.
        out_free = 1'b1;
        step();
        step();
        check("idle_pop_out", 32'(out_count), 32'd8);
        check("idle_hold_in", 32'(in_count), 32'd8);
        out_free = 1'b0;

        run_frame("base_empty", 12, 3, 5, -1, -1, -1, -1, 1'b0, 0);
        run_frame("img_full", 13, -1, -1, 3, 6, -1, -1, 1'b0, 4);
        run_frame("start_in_run", 9, -1, -1, -1, -1, 4, -1, 1'b0, 0);
        run_frame("mid_reset", 0, -1, -1, -1, -1, -1, 5, 1'b0, 0);
        run_frame("after_reset", 9, -1, -1, -1, -1, -1, -1, 1'b0, 0);
        run_frame("same_cycle", 8, -1, -1, -1, -1, -1, -1, 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
